// File: rtl/inst_fetch.sv
// Instruction fetch sequencer: byte-wide program memory to 16-bit decoder words.
// Optional INST_FETCH_NOP_SKIP_EN: consume 8'h00 opcodes without presenting them.
module inst_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic        mem_ready,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] inst,
    output logic        inst_valid,
    output logic [15:0] inst_pc,
    output logic [15:0] next_pc,
    input  logic        inst_ack,
    input  logic        pc_load,
    input  logic [15:0] pc_target
);

    typedef enum logic [1:0] {
        FETCH_OP,
        FETCH_ARG,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] pc;
    logic [15:0] pc_nxt;
    logic [15:0] pc_inc;
    logic [7:0]  op;
    logic [7:0]  op_nxt;
    logic [15:0] inst_nxt;
    logic [15:0] inst_pc_nxt;
    logic [15:0] next_pc_nxt;
    logic        is_nop;

    assign pc_inc = pc + 16'd1;

`ifdef INST_FETCH_NOP_SKIP_EN
    assign is_nop = (mem_rdata == 8'h00);
`else
    assign is_nop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH_OP;
            pc      <= RESET_PC;
            op      <= 8'h00;
            inst    <= 16'h0000;
            inst_pc <= RESET_PC;
            next_pc <= RESET_PC;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            op      <= op_nxt;
            inst    <= inst_nxt;
            inst_pc <= inst_pc_nxt;
            next_pc <= next_pc_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        op_nxt      = op;
        inst_nxt    = inst;
        inst_pc_nxt = inst_pc;
        next_pc_nxt = next_pc;
        mem_rd      = 1'b0;
        mem_addr    = pc;
        inst_valid  = 1'b0;

        case (state)
            FETCH_OP: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    pc_nxt = pc_inc;
                    if (is_nop) begin
                        state_nxt = FETCH_OP;
                    end else if (!mem_rdata[7]) begin
                        inst_nxt    = {mem_rdata, 8'h00};
                        inst_pc_nxt = pc;
                        next_pc_nxt = pc_inc;
                        state_nxt   = HOLD;
                    end else begin
                        op_nxt      = mem_rdata;
                        inst_pc_nxt = pc;
                        state_nxt   = FETCH_ARG;
                    end
                end
            end
            FETCH_ARG: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    inst_nxt    = {op, mem_rdata};
                    pc_nxt      = pc_inc;
                    next_pc_nxt = pc_inc;
                    state_nxt   = HOLD;
                end
            end
            HOLD: begin
                inst_valid = 1'b1;
                if (inst_ack) begin
                    state_nxt = FETCH_OP;
                end
            end
            default: begin
                state_nxt = FETCH_OP;
            end
        endcase

        // A redirect wins over any completing read or ack this cycle.
        if (pc_load) begin
            state_nxt   = FETCH_OP;
            pc_nxt      = pc_target;
            op_nxt      = op;
            inst_nxt    = inst;
            inst_pc_nxt = inst_pc;
            next_pc_nxt = next_pc;
        end

        if (rst) begin
            mem_rd = 1'b0;
        end
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch sequencer for the 16-bit CPU. It reads instruction bytes from the byte-wide program memory and assembles each instruction into a 16-bit word: opcode in the high byte, operand in the low byte. It then presents the word to the instruction decoder with a valid/ack handshake. It owns the program counter, handles one- and two-byte instruction lengths, and accepts branch redirects from the execute stage.

## Interface
Parameters:
- RESET_PC, 16'h0000, program counter value loaded by reset.

Ports:
- clk  input  1  core clock; all state changes on its rising edge.
- rst  input  1  reset. Synchronous and active-high.
- mem_rd  output  1  read request to program memory.
- mem_addr  output  16  byte address of the read. Stable while mem_rd is high.
- mem_ready  input  1  memory completes the read this cycle.
- mem_rdata  input  8  read data. Valid when mem_ready is high.
- inst  output  16  assembled instruction; drives decoder inst.
- inst_valid  output  1  inst is complete; drives decoder en.
- inst_pc  output  16  address of the opcode byte of inst.
- next_pc  output  16  address following the instruction (inst_pc + 1 or + 2).
- inst_ack  input  1  execute consumes inst this cycle.
- pc_load  input  1  redirect fetch to pc_target (branch taken).
- pc_target  input  16  redirect address.

## Operation
- State machine: FETCH_OP, FETCH_ARG, HOLD.
- **FETCH_OP**
  - mem_rd=1, mem_addr=pc.
  - On mem_ready, capture op=mem_rdata and pc←pc+1.
  - If op[7]=0 (zero-arg, 1 byte): inst={op,8'h00}, go to HOLD.
  - Otherwise go to FETCH_ARG.
- **FETCH_ARG**
  - mem_rd=1, mem_addr=pc.
  - On mem_ready, inst={op,mem_rdata}, pc←pc+1, go to HOLD.
- **HOLD**
  - inst_valid=1, mem_rd=0.
  - inst, inst_pc and next_pc are held stable.
  - On inst_ack, go to FETCH_OP. pc already equals next_pc.
- Without mem_ready, the current state is held and mem_addr does not change.
- **pc_load**
  - Highest priority in every state.
  - Next cycle: pc←pc_target, state FETCH_OP, inst_valid=0.
  - mem_ready or inst_ack in the same cycle are ignored; returned data is discarded.
  - An abandoned read is not reissued. Memory must tolerate mem_rd dropping or mem_addr changing after a request.
- **PC arithmetic**: modulo 2^16. 16'hFFFF+1 wraps to 16'h0000, including between the opcode and operand bytes of a two-byte instruction.
- **Reset values**
  - pc=RESET_PC, state FETCH_OP.
  - mem_rd=0 during the reset cycle, then 1 in the first cycle after reset.
  - inst=0, inst_valid=0, inst_pc=RESET_PC, next_pc=RESET_PC.
  - Reset mid-fetch abandons the read.

## Timing
- Zero-wait memory (mem_ready tied high):
  - 1-byte instruction: opcode read in cycle N, inst_valid in N+1.
  - 2-byte instruction: reads in N and N+1, inst_valid in N+2.
- An ack in cycle M starts the next opcode read in M+1.
- Peak throughput: one 1-byte instruction every 2 cycles; one 2-byte instruction every 3 cycles.
- Each wait state (mem_ready=0) adds exactly one cycle.
- pc_load in cycle M: the read of pc_target is issued in M+1.
- inst_valid never asserts in the same cycle as mem_rd.
- No combinational path from inst_ack or pc_load to mem_rd/mem_addr. Both are registered, with a one-cycle redirect latency.

## Configuration
- **INST_FETCH_NOP_SKIP_EN**
  - Defined: an opcode byte of 8'h00 (NOP) is consumed inside FETCH_OP. pc increments and the state stays in FETCH_OP with the next read issued the following cycle. inst_valid is not asserted for the NOP.
  - Not defined: NOP is presented like any other 1-byte instruction (inst=16'h0000, inst_valid=1) and waits for inst_ack.

## Test plan
- **Reset**: RESET_PC=16'h0100, zero-wait memory with bytes 0x07 at 0x0100. Expect the first read at 0x0100 in the cycle after reset. Expect inst=16'h0700, inst_valid=1, inst_pc=16'h0100, next_pc=16'h0101 one cycle later.
- **Two-byte instruction with wait states**: memory 0x88, 0x05 at 0x0000, mem_ready low for 2 cycles on each read.
  - Expect mem_addr stable during each wait.
  - Expect inst=16'h8805, next_pc=16'h0002 after 6 cycles.
  - Expect inst held until inst_ack.
- **Branch during FETCH_ARG**: pc_load=1 with pc_target=16'h0040 in the same cycle as mem_ready.
  - Expect the operand discarded and no inst_valid.
  - Expect the next read at 0x0040 one cycle later.
- **Ack/branch collision**: inst_valid=1 with inst_ack=1 and pc_load=1 (target 16'h0200). Expect the next read at 0x0200, not next_pc.
- **Wrap**: pc=16'hFFFF holding opcode 0x80, with 0x12 at 0x0000. Expect inst=16'h8012, inst_pc=16'hFFFF, next_pc=16'h0001.
- **NOP skip**: bytes 0x00, 0x00, 0x07.
  - With INST_FETCH_NOP_SKIP_EN: a single inst_valid with inst=16'h0700, inst_pc=16'h0002.
  - Without it: three presentations: 16'h0000, 16'h0000, 16'h0700.
